// File: rtl/sha256_msg_loader_if.sv
// Stream input and scheduler write/ack port of sha256_msg_loader.
// master is the loader side, slave is the host/scheduler side.
interface sha256_msg_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_nbytes;
    logic [31:0] message_word_out;
    logic [3:0]  message_word_addr;
    logic        write_enable_out;
    logic        start_new_block;
    logic        block_valid;
    logic        block_final;
    logic        block_ack;

    modport master (
        input  in_valid, in_data, in_last, in_nbytes, block_ack,
        output in_ready, message_word_out, message_word_addr, write_enable_out,
               start_new_block, block_valid, block_final
    );

    modport slave (
        output in_valid, in_data, in_last, in_nbytes, block_ack,
        input  in_ready, message_word_out, message_word_addr, write_enable_out,
               start_new_block, block_valid, block_final
    );
endinterface

// File: rtl/sha256_msg_loader.sv
// SHA-256 message loader: writes the message into the scheduler memory one 16-word block at a time.
// Define SHA256_LOADER_PAD_EN for hardware padding and length insertion; otherwise blocks arrive pre-padded.
//
// state    | meaning
// FILL     | accept input words, write each at wptr
// PAD      | write pending 0x80000000 or zero words
// LEN_HI   | write bitlen[63:32] at index 14
// LEN_LO   | write bitlen[31:0] at index 15
// WAIT_ACK | block_valid high, hold until block_ack
module sha256_msg_loader (
    input  logic                clk,
    input  logic                reset_n,
    sha256_msg_loader_if.master bus
);
    localparam logic [2:0] FILL     = 3'd0;
    localparam logic [2:0] WAIT_ACK = 3'd4;
`ifdef SHA256_LOADER_PAD_EN
    localparam logic [2:0] PAD      = 3'd1;
    localparam logic [2:0] LEN_HI   = 3'd2;
    localparam logic [2:0] LEN_LO   = 3'd3;
`endif

    logic [2:0] state;
    logic [3:0] wptr;
    logic       final_blk;
    logic       accept;

    assign accept = (state == FILL) && bus.in_ready && bus.in_valid;

`ifdef SHA256_LOADER_PAD_EN
    logic [63:0] bitlen;
    logic [2:0]  resume;
    logic        pend80;    // 0x80000000 still owed as the next pad word
    logic        overflow;  // 0x80 lands at 14/15: zero-fill this block, length goes in the next
    logic [31:0] last_word;
    logic [5:0]  add_bits;

    always_comb begin
        last_word = bus.in_data;
        case (bus.in_nbytes)
            2'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
            2'd2:    last_word = {bus.in_data[31:16], 16'h8000};
            2'd3:    last_word = {bus.in_data[31:8], 8'h80};
            default: last_word = bus.in_data;
        endcase
    end

    assign add_bits = (bus.in_last && bus.in_nbytes != 2'd0) ? {1'b0, bus.in_nbytes, 3'b000} : 6'd32;
`else
    logic unused_nbytes;
    assign unused_nbytes = ^bus.in_nbytes;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= FILL;
            wptr                  <= 4'd0;
            final_blk             <= 1'b0;
            bus.in_ready          <= 1'b0;
            bus.message_word_out  <= 32'd0;
            bus.message_word_addr <= 4'd0;
            bus.write_enable_out  <= 1'b0;
            bus.start_new_block   <= 1'b0;
            bus.block_valid       <= 1'b0;
            bus.block_final       <= 1'b0;
`ifdef SHA256_LOADER_PAD_EN
            bitlen                <= 64'd0;
            resume                <= FILL;
            pend80                <= 1'b0;
            overflow              <= 1'b0;
`endif
        end else begin
            bus.write_enable_out  <= 1'b0;
            bus.start_new_block   <= 1'b0;
            bus.message_word_out  <= 32'd0;
            bus.message_word_addr <= 4'd0;
            case (state)
                FILL: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        bus.write_enable_out  <= 1'b1;
                        bus.start_new_block   <= (wptr == 4'd0);
                        bus.message_word_addr <= wptr;
                        wptr                  <= wptr + 4'd1;
`ifdef SHA256_LOADER_PAD_EN
                        bitlen <= bitlen + {58'd0, add_bits};
                        if (bus.in_last) begin
                            bus.message_word_out <= last_word;
                            bus.in_ready         <= 1'b0;
                            pend80               <= (bus.in_nbytes == 2'd0);
                            if (wptr == 4'd15) begin
                                state     <= WAIT_ACK;
                                final_blk <= 1'b0;
                                resume    <= PAD;
                                overflow  <= 1'b0;
                            end else if (wptr == 4'd13 && bus.in_nbytes != 2'd0) begin
                                state <= LEN_HI;
                            end else begin
                                state    <= PAD;
                                overflow <= (wptr == 4'd14) || (wptr == 4'd13);
                            end
                        end else begin
                            bus.message_word_out <= bus.in_data;
                            if (wptr == 4'd15) begin
                                state        <= WAIT_ACK;
                                final_blk    <= 1'b0;
                                resume       <= FILL;
                                bus.in_ready <= 1'b0;
                            end
                        end
`else
                        bus.message_word_out <= bus.in_data;
                        if (wptr == 4'd15) begin
                            state        <= WAIT_ACK;
                            final_blk    <= bus.in_last;
                            bus.in_ready <= 1'b0;
                        end
`endif
                    end
                end
`ifdef SHA256_LOADER_PAD_EN
                PAD: begin
                    bus.write_enable_out  <= 1'b1;
                    bus.start_new_block   <= (wptr == 4'd0);
                    bus.message_word_addr <= wptr;
                    bus.message_word_out  <= pend80 ? 32'h8000_0000 : 32'd0;
                    pend80                <= 1'b0;
                    wptr                  <= wptr + 4'd1;
                    if (wptr == 4'd15) begin
                        state     <= WAIT_ACK;
                        final_blk <= 1'b0;
                        resume    <= PAD;
                        overflow  <= 1'b0;
                    end else if (!overflow && wptr == 4'd13) begin
                        state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    bus.write_enable_out  <= 1'b1;
                    bus.message_word_addr <= wptr;
                    bus.message_word_out  <= bitlen[63:32];
                    wptr                  <= wptr + 4'd1;
                    state                 <= LEN_LO;
                end
                LEN_LO: begin
                    bus.write_enable_out  <= 1'b1;
                    bus.message_word_addr <= wptr;
                    bus.message_word_out  <= bitlen[31:0];
                    wptr                  <= wptr + 4'd1;
                    state                 <= WAIT_ACK;
                    final_blk             <= 1'b1;
                end
`endif
                WAIT_ACK: begin
                    bus.in_ready <= 1'b0;
                    // valid rises one cycle after entry so it follows the index-15 write
                    if (!bus.block_valid) begin
                        bus.block_valid <= 1'b1;
                        bus.block_final <= final_blk;
                    end else if (bus.block_ack) begin
                        bus.block_valid <= 1'b0;
                        bus.block_final <= 1'b0;
                        wptr            <= 4'd0;
`ifdef SHA256_LOADER_PAD_EN
                        if (final_blk) begin
                            state        <= FILL;
                            bus.in_ready <= 1'b1;
                            bitlen       <= 64'd0;
                        end else begin
                            state        <= resume;
                            bus.in_ready <= (resume == FILL);
                        end
`else
                        state        <= FILL;
                        bus.in_ready <= 1'b1;
`endif
                    end
                end
                default: begin
                    state        <= FILL;
                    wptr         <= 4'd0;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
